// File: rtl/prim_alert_ping_scheduler.sv
// prim_alert_ping_scheduler
//
// Pings a bank of alert sender channels one at a time, in round-robin order.
// The scheduler idles for a programmable number of cycles, selects the next
// enabled channel, and holds that channel's ping request until the sender
// answers with a ping-ok pulse or a programmable timeout expires. A channel
// that times out gets a sticky fail flag, which stays set until fail_clr_i.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   en_i           scheduler enable
//   wait_cyc_i     idle cycles between pings, sampled when the wait counter reloads
//   timeout_cyc_i  ping response timeout, sampled when a channel is selected
//   alert_en_i     per-channel ping enable mask
//   ping_ok_i      per-channel ping-response pulse from the senders
//   fail_clr_i     clear all ping_fail_o bits
//   ping_req_o     one-hot (or zero) level ping request
//   ping_idx_o     index of the current or most recently pinged channel
//   ping_fail_o    sticky per-channel timeout flags
//   busy_o         high whenever the scheduler is not idle

module prim_alert_ping_scheduler #(
    parameter int unsigned NumAlerts = 4,
    parameter int unsigned CntW      = 16,
    localparam int unsigned IdxW     = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CntW-1:0]      wait_cyc_i,
    input  logic [CntW-1:0]      timeout_cyc_i,
    input  logic [NumAlerts-1:0] alert_en_i,
    input  logic [NumAlerts-1:0] ping_ok_i,
    input  logic                 fail_clr_i,
    output logic [NumAlerts-1:0] ping_req_o,
    output logic [IdxW-1:0]      ping_idx_o,
    output logic [NumAlerts-1:0] ping_fail_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SELECT,
        ST_PING,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]      ping_idx_q, ping_idx_d;
    logic [NumAlerts-1:0] ping_fail_q, ping_fail_d;

    // Round-robin search: first enabled channel at or after rr_ptr, wrapping.
    // rr_ptr and the loop index are both below NumAlerts, so a single
    // conditional subtract replaces a general modulo.
    logic            sel_found;
    logic [IdxW-1:0] sel_idx;
    logic [IdxW-1:0] sel_next;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NumAlerts; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NumAlerts) begin
                cand = cand - NumAlerts;
            end
            cand_idx = IdxW'(cand);
            if (!sel_found && alert_en_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        sel_next = (sel_idx == IdxW'(NumAlerts - 1)) ? '0 : sel_idx + IdxW'(1);
    end

    // Next-state logic.
    // NOTE: every signal this block writes gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        ping_idx_d  = ping_idx_q;
        ping_fail_d = fail_clr_i ? '0 : ping_fail_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_cyc_i;
                end
            end
            ST_WAIT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    state_d    = ST_PING;
                    ping_idx_d = sel_idx;
                    rr_ptr_d   = sel_next;
                    cnt_d      = timeout_cyc_i;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_cyc_i;
                end
            end
            ST_PING: begin
                // en_i and alert_en_i are deliberately ignored here: the
                // handshake always completes so a sender is never left
                // mid-ping. A response arriving on the timeout cycle wins.
                if (ping_ok_i[ping_idx_q]) begin
                    state_d = ST_GAP;
                end else if (cnt_q == '0) begin
                    state_d                 = ST_GAP;
                    ping_fail_d[ping_idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ST_GAP: begin
                if (en_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_cyc_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            ping_idx_q  <= '0;
            ping_fail_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ping_idx_q  <= ping_idx_d;
            ping_fail_q <= ping_fail_d;
        end
    end

    // Outputs decode flops only, so nothing on an input reaches them
    // combinationally.
    always_comb begin
        ping_req_o = '0;
        if (state_q == ST_PING) begin
            ping_req_o[ping_idx_q] = 1'b1;
        end
    end

    assign ping_idx_o  = ping_idx_q;
    assign ping_fail_o = ping_fail_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
